lsu: RTL

LSU -- requirements
Module: lsu

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/lsu_load_align.sv | 28 ++
 rtl/lsu.sv | 136 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes,
// FSM state encoding and the access legality check.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } lsu_state_e;

    // Unsigned codes only exist for loads; stores accept b/h/w.
    function automatic logic access_error(
        input logic       wr,
        input logic [2:0] f3,
        input logic [1:0] ofs
    );
        logic err;
        err = 1'b0;
        case (f3)
            F3_B:    err = 1'b0;
            F3_BU:   err = wr;
            F3_H:    err = ofs[0];
            F3_HU:   err = ofs[0] | wr;
            F3_W:    err = (ofs != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data extraction: picks the addressed byte/half out of the
// memory word and sign- or zero-extends it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        data     = rdata;
        unique case (1'b1)
            funct3 == F3_B:  data = {{24{byte_sel[7]}}, byte_sel};
            funct3 == F3_BU: data = {24'b0, byte_sel};
            funct3 == F3_H:  data = {{16{half_sel[15]}}, half_sel};
            funct3 == F3_HU: data = {16'b0, half_sel};
            default:         data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single outstanding access, word-addressed memory
// port with byte enables and fixed read latency.
module lsu
    import lsu_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_rdata
);

    localparam int CW = 2;

    lsu_state_e    state;
    lsu_state_e    state_nx;
    logic          wr_q;
    logic [2:0]    f3_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic [CW-1:0] cnt_q;
    logic          accept;
    logic          req_err;
    logic [3:0]    be_raw;
    logic [31:0]   load_data;

    assign accept  = req_valid & req_ready;
    assign req_err = access_error(req_write, req_funct3, req_addr[1:0]);

    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        resp_valid = 1'b0;
        unique case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_nx = req_err ? S_RESP : S_ISSUE;
            end
            S_ISSUE: begin
                mem_write = wr_q;
                mem_read  = ~wr_q;
                state_nx  = wr_q ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0)
                    state_nx = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                state_nx   = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Store lanes are derived from the latched request only.
    always_comb begin
        mem_wdata = wdata_q;
        be_raw    = 4'b1111;
        unique case (1'b1)
            f3_q[1:0] == 2'b00: begin
                mem_wdata = {4{wdata_q[7:0]}};
                be_raw    = 4'b0001 << addr_q[1:0];
            end
            f3_q[1:0] == 2'b01: begin
                mem_wdata = {2{wdata_q[15:0]}};
                be_raw    = addr_q[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                mem_wdata = wdata_q;
                be_raw    = 4'b1111;
            end
        endcase
    end

    assign mem_be     = mem_write ? be_raw : 4'b0000;
    assign mem_addr   = {addr_q[31:2], 2'b00};
    assign resp_rdata = rdata_q;
    assign resp_error = resp_valid & err_q;

    lsu_load_align u_align (
        .rdata  (mem_rdata),
        .offset (addr_q[1:0]),
        .funct3 (f3_q),
        .data   (load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            wr_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                wr_q    <= req_write;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                err_q   <= req_err;
                rdata_q <= '0;
            end
            if (state == S_ISSUE && !wr_q)
                cnt_q <= CW'(RD_LATENCY - 1);
            else if (state == S_WAIT && cnt_q != '0)
                cnt_q <= cnt_q - 1'b1;
            if (state == S_WAIT && cnt_q == '0)
                rdata_q <= load_data;
        end
    end

endmodule
